wb_stage: RTL

- Write-back stage of the tinyriscv pipeline. It sits directly upstream of the register file.
- Accepts one retiring instruction per cycle from the memory stage and selects the result source (ALU, load data, PC+4).
- Aligns and extends load data, waits for the data-memory response on loads, and drives the register file write port (rf_we/rf_a3/rf_wd).
- Exposes the same value as a forwarding source and keeps a retire counter.

---
 rtl/wb_stage_if.sv | 34 +++
 rtl/wb_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/wb_stage_if.sv
// Memory-stage / data-memory / register-file bundle seen by the write-back stage.
// The master modport is the pipeline side; the slave modport is wb_stage itself.
interface wb_stage_if #(
    parameter int CNT_W = 32
);
    logic             m_valid;
    logic             m_ready;
    logic             m_regwrite;
    logic [4:0]       m_rd;
    logic [1:0]       m_wdsel;
    logic [31:0]      m_alu_result;
    logic [31:0]      m_pc_plus4;
    logic [2:0]       m_funct3;
    logic             dm_rvalid;
    logic [31:0]      dm_rdata;
    logic             rf_we;
    logic [4:0]       rf_a3;
    logic [31:0]      rf_wd;
    logic             fwd_valid;
    logic             ld_err;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output m_valid, m_regwrite, m_rd, m_wdsel, m_alu_result, m_pc_plus4, m_funct3,
        output dm_rvalid, dm_rdata,
        input  m_ready, rf_we, rf_a3, rf_wd, fwd_valid, ld_err, retire_cnt
    );

    modport slave (
        input  m_valid, m_regwrite, m_rd, m_wdsel, m_alu_result, m_pc_plus4, m_funct3,
        input  dm_rvalid, dm_rdata,
        output m_ready, rf_we, rf_a3, rf_wd, fwd_valid, ld_err, retire_cnt
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: result select, load align/extend with timeout, register-file write port.
// Latency 1 cycle for non-loads, response+1 for loads; m_ready drops only while a load waits.
module wb_stage #(
    parameter int TIMEOUT_W = 8,
    parameter int CNT_W     = 32
) (
    input  logic      clk,
    input  logic      rst,
    wb_stage_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WB = 2'd1, S_WAIT = 2'd2} state_t;

    state_t               r_state;
    state_t               w_next;

    logic                 r_ld_regwrite;
    logic [4:0]           r_ld_rd;
    logic [2:0]           r_ld_funct3;
    logic [1:0]           r_ld_addr;
    logic [TIMEOUT_W-1:0] r_wait_cnt;

    logic                 r_we;
    logic [4:0]           r_a3;
    logic [31:0]          r_wd;
    logic                 r_err;
    logic [CNT_W-1:0]     r_retire;

    logic                 w_accept;
    logic                 w_is_load;
    logic [TIMEOUT_W-1:0] w_cnt_inc;
    logic                 w_timeout;
    logic                 w_ld_done;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_ld_data;
    logic                 w_ld_bad;

    assign w_accept  = bus.m_valid && (r_state != S_WAIT);
    assign w_is_load = (bus.m_wdsel == 2'b01);
    assign w_cnt_inc = r_wait_cnt + 1'b1;
    assign w_timeout = (w_cnt_inc == {TIMEOUT_W{1'b1}});
    assign w_ld_done = (r_state == S_WAIT) && (bus.dm_rvalid || w_timeout);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_WB: begin
                if (w_accept) begin
                    w_next = w_is_load ? S_WAIT : S_WB;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (bus.dm_rvalid || w_timeout) begin
                    w_next = S_WB;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic: write-port strobes exist only in the WB cycle
    always_comb begin
        bus.m_ready    = (r_state != S_WAIT);
        bus.rf_we      = (r_state == S_WB) && r_we;
        bus.fwd_valid  = (r_state == S_WB) && r_we;
        bus.ld_err     = (r_state == S_WB) && r_err;
        bus.rf_a3      = r_a3;
        bus.rf_wd      = r_wd;
        bus.retire_cnt = r_retire;
    end

    assign w_byte = bus.dm_rdata[{r_ld_addr, 3'b000} +: 8];
    assign w_half = r_ld_addr[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];

    always_comb begin
        w_ld_data = 32'd0;
        w_ld_bad  = 1'b0;
        case (r_ld_funct3)
            3'b000: w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b001: begin
                w_ld_data = {{16{w_half[15]}}, w_half};
                w_ld_bad  = r_ld_addr[0];
            end
            3'b010: begin
                w_ld_data = bus.dm_rdata;
                w_ld_bad  = (r_ld_addr != 2'b00);
            end
            3'b100: w_ld_data = {24'd0, w_byte};
            3'b101: begin
                w_ld_data = {16'd0, w_half};
                w_ld_bad  = r_ld_addr[0];
            end
            default: w_ld_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_regwrite <= 1'b0;
            r_ld_rd       <= 5'd0;
            r_ld_funct3   <= 3'd0;
            r_ld_addr     <= 2'd0;
            r_wait_cnt    <= '0;
        end else if (w_accept && w_is_load) begin
            r_ld_regwrite <= bus.m_regwrite;
            r_ld_rd       <= bus.m_rd;
            r_ld_funct3   <= bus.m_funct3;
            r_ld_addr     <= bus.m_alu_result[1:0];
            r_wait_cnt    <= '0;
        end else if ((r_state == S_WAIT) && !bus.dm_rvalid) begin
            r_wait_cnt    <= w_cnt_inc;
        end
    end

    // A timed-out or faulty load retires with a zero, unwritten result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we  <= 1'b0;
            r_a3  <= 5'd0;
            r_wd  <= 32'd0;
            r_err <= 1'b0;
        end else if (w_accept && !w_is_load) begin
            r_we  <= bus.m_regwrite && (bus.m_rd != 5'd0);
            r_a3  <= bus.m_rd;
            r_wd  <= (bus.m_wdsel == 2'b10) ? bus.m_pc_plus4 : bus.m_alu_result;
            r_err <= 1'b0;
        end else if (w_ld_done) begin
            r_we  <= bus.dm_rvalid && !w_ld_bad && r_ld_regwrite && (r_ld_rd != 5'd0);
            r_a3  <= r_ld_rd;
            r_wd  <= (bus.dm_rvalid && !w_ld_bad) ? w_ld_data : 32'd0;
            r_err <= !bus.dm_rvalid || w_ld_bad;
        end
    end

    // Counted on entry to WB so the WB cycle already shows its own retirement
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retire <= '0;
        end else if (w_next == S_WB) begin
            r_retire <= r_retire + 1'b1;
        end
    end
endmodule
